// File: rtl/time_display_driver_pkg.sv
// Shared types and constants for the MM:SS display driver: FSM states,
// digit indices, double-dabble helpers and the 7-segment lookup.
package time_display_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One double-dabble iteration per input bit.
    localparam int ITER_COUNT = 6;

    localparam logic [1:0] DIG_SEC_ONES = 2'd0;
    localparam logic [1:0] DIG_SEC_TENS = 2'd1;
    localparam logic [1:0] DIG_MIN_ONES = 2'd2;
    localparam logic [1:0] DIG_MIN_TENS = 2'd3;

    // Active-high gfedcba patterns; codes 10..15 are blank.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
    };

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        return SEG_LUT[digit];
    endfunction

    function automatic logic [3:0] dd_adjust(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
    endfunction

endpackage

// File: rtl/time_display_driver_bin2bcd_seq.sv
// Serial 6-bit double-dabble converter: i_start loads the value, then six
// add-3/shift iterations follow; o_done flags the cycle of the last shift.
module bin2bcd_seq
    import time_display_driver_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [5:0] i_bin,
    output logic [7:0] o_bcd,
    output logic       o_done
);

    logic [13:0] r_shift;
    logic [2:0]  r_cnt;
    logic        r_active;
    logic [13:0] w_adj;
    logic        w_last;

    assign w_adj  = {dd_adjust(r_shift[13:10]), dd_adjust(r_shift[9:6]), r_shift[5:0]};
    assign w_last = (r_cnt == 3'(ITER_COUNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_shift  <= {8'h00, i_bin};
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_shift <= {w_adj[12:0], 1'b0};
            if (w_last) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    assign o_bcd  = r_shift[13:6];
    assign o_done = r_active && w_last;

endmodule

// File: rtl/time_display_driver.sv
// MM:SS display driver: converts binary second/minute to BCD on change and
// scans the four digits of a multiplexed 7-segment display.
module time_display_driver
    import time_display_driver_pkg::*;
#(
    parameter int SCAN_DIV       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] second,
    input  logic [5:0] minute,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       busy,
    output logic       conv_done,
    output logic [6:0] seg,
    output logic [3:0] dig_sel
);

    localparam int         DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_INV = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    state_t      r_state;
    state_t      w_state_next;
    logic [11:0] r_snap;
    logic [7:0]  r_sec_bcd;
    logic [7:0]  r_min_bcd;
    logic        r_conv_done;
    logic        w_change;
    logic        w_start;
    logic        w_load;
    logic        w_busy;
    logic [7:0]  w_sec_conv;
    logic [7:0]  w_min_conv;
    logic        w_sec_done;
    logic        w_min_done;

    assign w_change = ({minute, second} != r_snap);

    bin2bcd_seq u_sec_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_bin   (second),
        .o_bcd   (w_sec_conv),
        .o_done  (w_sec_done)
    );

    bin2bcd_seq u_min_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_bin   (minute),
        .o_bcd   (w_min_conv),
        .o_done  (w_min_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_change) w_state_next = ST_CONV;
            ST_CONV: if (w_sec_done && w_min_done) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_start = 1'b0;
        w_load  = 1'b0;
        w_busy  = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy  = 1'b0;
                w_start = w_change;
            end
            ST_DONE: w_load = 1'b1;
            default: ;
        endcase
    end

    // Inputs seen while busy are not latched; the snapshot only moves at capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap      <= '0;
            r_sec_bcd   <= 8'h00;
            r_min_bcd   <= 8'h00;
            r_conv_done <= 1'b0;
        end else begin
            r_conv_done <= w_load;
            if (w_start) begin
                r_snap <= {minute, second};
            end
            if (w_load) begin
                r_sec_bcd <= w_sec_conv;
                r_min_bcd <= w_min_conv;
            end
        end
    end

    assign sec_bcd   = r_sec_bcd;
    assign min_bcd   = r_min_bcd;
    assign busy      = w_busy;
    assign conv_done = r_conv_done;

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_idx;
    logic [6:0]       r_seg;
    logic [3:0]       r_dig_sel;
    logic             w_wrap;
    logic [1:0]       w_idx_next;
    logic [3:0]       w_digit;

    assign w_wrap     = (r_div == DIV_MAX);
    assign w_idx_next = w_wrap ? r_idx + 2'd1 : r_idx;

    always_comb begin
        w_digit = r_sec_bcd[3:0];
        case (w_idx_next)
            DIG_SEC_ONES: w_digit = r_sec_bcd[3:0];
            DIG_SEC_TENS: w_digit = r_sec_bcd[7:4];
            DIG_MIN_ONES: w_digit = r_min_bcd[3:0];
            DIG_MIN_TENS: w_digit = r_min_bcd[7:4];
            default:      w_digit = r_sec_bcd[3:0];
        endcase
    end

    // seg and dig_sel are both derived from the next index so they move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div     <= '0;
            r_idx     <= DIG_SEC_ONES;
            r_seg     <= SEG_LUT[0] ^ SEG_INV;
            r_dig_sel <= 4'b0001;
        end else begin
            r_div     <= w_wrap ? '0 : r_div + DIV_W'(1);
            r_idx     <= w_idx_next;
            r_seg     <= seg_encode(w_digit) ^ SEG_INV;
            r_dig_sel <= 4'b0001 << w_idx_next;
        end
    end

    assign seg     = r_seg;
    assign dig_sel = r_dig_sel;

endmodule

// File: tb/tb_time_display_driver.sv
// Directed bench for time_display_driver: conversion latency, boundaries,
// back-to-back changes, digit scan (both polarities) and mid-conversion reset.
module tb_time_display_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] second;
    logic [5:0] minute;
    logic [7:0] sec_bcd, min_bcd, sec_bcd_i, min_bcd_i;
    logic       busy, conv_done, busy_i, conv_done_i;
    logic [6:0] seg, seg_i;
    logic [3:0] dig_sel, dig_sel_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor results filled in by watch()
    int         busy_cnt, done_cnt, min_chg;
    int         done_tick [2];
    logic [7:0] done_sec [2];
    logic [7:0] done_min [2];

    always #5 clk = ~clk;

    time_display_driver #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .second(second), .minute(minute),
        .sec_bcd(sec_bcd), .min_bcd(min_bcd), .busy(busy), .conv_done(conv_done),
        .seg(seg), .dig_sel(dig_sel)
    );

    time_display_driver #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut_inv (
        .clk(clk), .rst_n(rst_n), .second(second), .minute(minute),
        .sec_bcd(sec_bcd_i), .min_bcd(min_bcd_i), .busy(busy_i), .conv_done(conv_done_i),
        .seg(seg_i), .dig_sel(dig_sel_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles, tallying busy/conv_done and min_bcd changes; optionally
    // drives second=new_sec after tick number change_at.
    task automatic watch(input int n, input int change_at, input logic [5:0] new_sec);
        logic [7:0] prev_min;
        busy_cnt = 0; done_cnt = 0; min_chg = 0;
        done_tick[0] = -1; done_tick[1] = -1;
        done_sec[0] = 'x; done_sec[1] = 'x; done_min[0] = 'x; done_min[1] = 'x;
        prev_min = min_bcd;
        for (int t = 1; t <= n; t++) begin
            tick();
            if (busy) busy_cnt++;
            if (min_bcd !== prev_min) min_chg++;
            prev_min = min_bcd;
            if (conv_done) begin
                if (done_cnt < 2) begin
                    done_tick[done_cnt] = t;
                    done_sec[done_cnt]  = sec_bcd;
                    done_min[done_cnt]  = min_bcd;
                end
                done_cnt++;
            end
            if (t == change_at) second = new_sec;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; second = 6'd0; minute = 6'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        n_checks++; if (sec_bcd !== 8'h00) begin n_fail++; $display("FAIL reset_sec_bcd got %h want 00", sec_bcd); end
        n_checks++; if (min_bcd !== 8'h00) begin n_fail++; $display("FAIL reset_min_bcd got %h want 00", min_bcd); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (conv_done !== 1'b0) begin n_fail++; $display("FAIL reset_conv_done got %b want 0", conv_done); end
        n_checks++; if (seg !== 7'h3F) begin n_fail++; $display("FAIL reset_seg got %h want 3f", seg); end
        n_checks++; if (seg_i !== 7'h40) begin n_fail++; $display("FAIL reset_seg_inv got %h want 40", seg_i); end
        n_checks++; if (dig_sel !== 4'b0001) begin n_fail++; $display("FAIL reset_dig_sel got %b want 0001", dig_sel); end
        watch(50, 0, 6'd0);
        n_checks++; if (busy_cnt !== 0) begin n_fail++; $display("FAIL idle_busy cycles got %0d want 0", busy_cnt); end
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL idle_conv_done pulses got %0d want 0", done_cnt); end
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        second = 6'd37; minute = 6'd12;
        watch(12, 0, 6'd0);
        n_checks++; if (busy_cnt !== 7) begin n_fail++; $display("FAIL basic_busy_len got %0d want 7", busy_cnt); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
        n_checks++; if (done_tick[0] !== 8) begin n_fail++; $display("FAIL basic_latency got %0d want 8", done_tick[0]); end
        n_checks++; if (done_sec[0] !== 8'h37) begin n_fail++; $display("FAIL basic_sec_bcd got %h want 37", done_sec[0]); end
        n_checks++; if (done_min[0] !== 8'h12) begin n_fail++; $display("FAIL basic_min_bcd got %h want 12", done_min[0]); end
        $display("test_basic: 12:37 -> %h:%h", min_bcd, sec_bcd);
    endtask

    task automatic test_scan();
        logic [3:0] prev_sel;
        logic [3:0] exp_sel [4];
        logic [6:0] exp_seg [4];
        logic [6:0] exp_inv [4];
        bit         found;
        exp_sel = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_seg = '{7'h07, 7'h4F, 7'h5B, 7'h06};
        exp_inv = '{7'h78, 7'h30, 7'h24, 7'h79};
        found = 1'b0;
        prev_sel = dig_sel;
        for (int t = 0; t < 24 && !found; t++) begin
            tick();
            if (dig_sel == 4'b0001 && prev_sel == 4'b1000) found = 1'b1;
            prev_sel = dig_sel;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL scan_align got no 1000->0001 transition want one within 24 cycles"); end
        for (int k = 0; k < 16; k++) begin
            n_checks++; if (dig_sel !== exp_sel[k/4]) begin n_fail++; $display("FAIL scan_dig_sel[%0d] got %b want %b", k, dig_sel, exp_sel[k/4]); end
            n_checks++; if (seg !== exp_seg[k/4]) begin n_fail++; $display("FAIL scan_seg[%0d] got %h want %h", k, seg, exp_seg[k/4]); end
            n_checks++; if (seg_i !== exp_inv[k/4]) begin n_fail++; $display("FAIL scan_seg_inv[%0d] got %h want %h", k, seg_i, exp_inv[k/4]); end
            tick();
        end
        $display("test_scan: 16 cycles checked");
    endtask

    task automatic test_boundary();
        second = 6'd60; minute = 6'd60;
        watch(12, 0, 6'd0);
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL b60_done_count got %0d want 1", done_cnt); end
        n_checks++; if (done_sec[0] !== 8'h60) begin n_fail++; $display("FAIL b60_sec_bcd got %h want 60", done_sec[0]); end
        n_checks++; if (done_min[0] !== 8'h60) begin n_fail++; $display("FAIL b60_min_bcd got %h want 60", done_min[0]); end
        $display("test_boundary: 60:60 -> %h:%h", min_bcd, sec_bcd);
        second = 6'd63;
        watch(12, 0, 6'd0);
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL b63_done_count got %0d want 1", done_cnt); end
        n_checks++; if (done_sec[0] !== 8'h63) begin n_fail++; $display("FAIL b63_sec_bcd got %h want 63", done_sec[0]); end
        n_checks++; if (min_chg !== 0) begin n_fail++; $display("FAIL b63_min_glitch changes got %0d want 0", min_chg); end
        n_checks++; if (min_bcd !== 8'h60) begin n_fail++; $display("FAIL b63_min_bcd got %h want 60", min_bcd); end
        $display("test_boundary: 60:63 -> %h:%h", min_bcd, sec_bcd);
    endtask

    task automatic test_back_to_back();
        second = 6'd5;
        watch(24, 2, 6'd6);
        n_checks++; if (done_cnt !== 2) begin n_fail++; $display("FAIL b2b_done_count got %0d want 2", done_cnt); end
        n_checks++; if (done_tick[0] !== 8) begin n_fail++; $display("FAIL b2b_first_tick got %0d want 8", done_tick[0]); end
        n_checks++; if (done_sec[0] !== 8'h05) begin n_fail++; $display("FAIL b2b_first_sec got %h want 05", done_sec[0]); end
        n_checks++; if (done_tick[1] !== 16) begin n_fail++; $display("FAIL b2b_second_tick got %0d want 16", done_tick[1]); end
        n_checks++; if (done_sec[1] !== 8'h06) begin n_fail++; $display("FAIL b2b_second_sec got %h want 06", done_sec[1]); end
        $display("test_back_to_back: pulses=%0d final sec=%h", done_cnt, sec_bcd);
    endtask

    task automatic test_reset_mid_conv();
        int rst_done;
        second = 6'd45;
        repeat (3) tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        n_checks++; if (sec_bcd !== 8'h00) begin n_fail++; $display("FAIL mid_rst_sec got %h want 00", sec_bcd); end
        n_checks++; if (min_bcd !== 8'h00) begin n_fail++; $display("FAIL mid_rst_min got %h want 00", min_bcd); end
        n_checks++; if (dig_sel !== 4'b0001) begin n_fail++; $display("FAIL mid_rst_dig_sel got %b want 0001", dig_sel); end
        n_checks++; if (seg !== 7'h3F) begin n_fail++; $display("FAIL mid_rst_seg got %h want 3f", seg); end
        rst_done = 0;
        for (int t = 0; t < 4; t++) begin
            tick();
            if (conv_done) rst_done++;
        end
        n_checks++; if (rst_done !== 0) begin n_fail++; $display("FAIL mid_rst_conv_done pulses got %0d want 0", rst_done); end
        rst_n = 1'b1;
        watch(12, 0, 6'd0);
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL mid_after_done_count got %0d want 1", done_cnt); end
        n_checks++; if (done_tick[0] !== 8) begin n_fail++; $display("FAIL mid_after_latency got %0d want 8", done_tick[0]); end
        n_checks++; if (done_sec[0] !== 8'h45) begin n_fail++; $display("FAIL mid_after_sec got %h want 45", done_sec[0]); end
        n_checks++; if (done_min[0] !== 8'h60) begin n_fail++; $display("FAIL mid_after_min got %h want 60", done_min[0]); end
        $display("test_reset_mid_conv: after release %h:%h", min_bcd, sec_bcd);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_scan();
        test_boundary();
        test_back_to_back();
        test_reset_mid_conv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
